vend_ctrl_multi: RTL and testbench

Parametrised vending controller that replaces the fixed four-item, per-item FSM arrangement with one shared credit accumulator and one FSM. It supports NUM_ITEMS items with per-item prices and accepts 5- and 10-unit coins. It adds behaviour the fixed design lacks: item selection in any order relative to coins, multi-coin change return, cancel/refund, overflow coin rejection and a busy indication. It sits between the coin/keypad front end and the dispenser/change hopper drivers.

---
 rtl/vend_ctrl_multi.sv | 115 +++++++++++
 tb/tb_vend_ctrl_multi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: shared-credit vending controller for NUM_ITEMS priced items.
// Accepts 5/10-unit coins in any order relative to item selection, vends once
// credit covers the selected price, pays change as single 5-unit coins, and
// supports cancel/refund and overflow rejection.
module vend_ctrl_multi #(
    parameter int                     NUM_ITEMS  = 4,
    parameter int                     ITEM_W     = 2,
    parameter int                     CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*8-1:0] PRICES     = {8'd9, 8'd7, 8'd5, 8'd3},
    parameter int                     MAX_CREDIT = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ITEM_W-1:0]   item_sel,
    input  logic                item_valid,
    input  logic                five_in,
    input  logic                ten_in,
    input  logic                cancel,
    output logic                dispense,
    output logic [ITEM_W-1:0]   dispense_item,
    output logic                five_out,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_VEND, S_CHANGE} state_t;

    // Wide enough for credit + 2 and any 8-bit price without wrap.
    localparam int SW = CREDIT_W + 9;
    localparam logic [SW-1:0]     MAX_W = SW'(MAX_CREDIT);
    localparam logic [ITEM_W:0]   NI    = (ITEM_W + 1)'(NUM_ITEMS);

    state_t              state, state_nxt;
    logic [ITEM_W-1:0]   sel;
    logic [7:0]          price_sel;
    logic [SW-1:0]       cred_w, price_w, remain_w;
    logic                open_st, item_ok, can_vend;
    logic                acc_ten, acc_five, rej_nxt;

    // Price of the currently latched item.
    always_comb begin
        price_sel = 8'd0;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (sel == ITEM_W'(i)) price_sel = PRICES[i*8 +: 8];
    end

    assign cred_w   = SW'(credit);
    assign price_w  = SW'(price_sel);
    assign remain_w = cred_w - price_w;
    assign open_st  = (state == S_IDLE) || (state == S_SEL);
    assign item_ok  = item_valid && ({1'b0, item_sel} < NI);
    // Decided on registered credit; coins arriving on the same edge still count.
    assign can_vend = (state == S_SEL) && (cred_w >= price_w);
    // A simultaneous five is always refused in favour of the ten.
    assign acc_ten  = open_st && !cancel && ten_in && (cred_w + SW'(2) <= MAX_W);
    assign acc_five = open_st && !cancel && five_in && !ten_in
                      && (cred_w + SW'(1) <= MAX_W);
    assign rej_nxt  = (ten_in && !acc_ten) || (five_in && !acc_five);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; cancel outranks vending and selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_SEL: begin
                if (cancel)        state_nxt = (credit != '0) ? S_CHANGE : S_IDLE;
                else if (can_vend) state_nxt = S_VEND;
                else if (item_ok)  state_nxt = S_SEL;
            end
            S_VEND:   state_nxt = (remain_w != '0) ? S_CHANGE : S_IDLE;
            S_CHANGE: state_nxt = (credit == CREDIT_W'(1)) ? S_IDLE : S_CHANGE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state and selection.
    always_comb begin
        dispense      = (state == S_VEND);
        dispense_item = (state == S_VEND) ? sel : '0;
        five_out      = (state == S_CHANGE);
        busy          = (state == S_VEND) || (state == S_CHANGE);
    end

    // Credit, selection and coin-reject registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit      <= '0;
            sel         <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= rej_nxt;
            case (state)
                S_IDLE, S_SEL: begin
                    credit <= credit + (acc_ten  ? CREDIT_W'(2) :
                                        acc_five ? CREDIT_W'(1) : '0);
                    if (cancel)                    sel <= '0;
                    else if (!can_vend && item_ok) sel <= item_sel;
                end
                S_VEND: begin
                    credit <= remain_w[CREDIT_W-1:0];
                    sel    <= '0;
                end
                S_CHANGE: credit <= credit - CREDIT_W'(1);
                default:  credit <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed scenarios plus randomized traffic, checked every
// cycle against a credit/selection model; a second 3-item instance covers the
// out-of-range selection case.
module tb_vend_ctrl_multi;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] item_sel;
    logic       item_valid, five_in, ten_in, cancel;
    logic       dispense, five_out, coin_reject, busy;
    logic [1:0] dispense_item;
    logic [7:0] credit;

    logic [1:0] b_item_sel;
    logic       b_item_valid, b_five_in, b_ten_in, b_cancel;
    logic       b_dispense, b_five_out, b_coin_reject, b_busy;
    logic [1:0] b_dispense_item;
    logic [7:0] b_credit;

    int checks = 0, failures = 0;
    int disp_cnt = 0, five_cnt = 0, b_disp_cnt = 0, b_five_cnt = 0;

    always #5 clock = ~clock;

    vend_ctrl_multi dut (
        .clock(clock), .reset(reset), .item_sel(item_sel), .item_valid(item_valid),
        .five_in(five_in), .ten_in(ten_in), .cancel(cancel), .dispense(dispense),
        .dispense_item(dispense_item), .five_out(five_out), .coin_reject(coin_reject),
        .busy(busy), .credit(credit)
    );

    vend_ctrl_multi #(.NUM_ITEMS(3), .ITEM_W(2), .PRICES({8'd7, 8'd5, 8'd3})) dut3 (
        .clock(clock), .reset(reset), .item_sel(b_item_sel), .item_valid(b_item_valid),
        .five_in(b_five_in), .ten_in(b_ten_in), .cancel(b_cancel), .dispense(b_dispense),
        .dispense_item(b_dispense_item), .five_out(b_five_out),
        .coin_reject(b_coin_reject), .busy(b_busy), .credit(b_credit)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: credit, selected item (-1 = none), a pending vend and a refund
    // in progress where the remaining credit is paid one coin per cycle.
    int  price [4] = '{3, 5, 7, 9};
    int  m_credit, m_sel;
    bit  m_vend, m_refund, m_rej;

    always @(posedge clock or posedge reset) begin
        int c, s; bit v, r, rj, coin;
        if (reset) begin
            m_credit <= 0; m_sel <= -1; m_vend <= 0; m_refund <= 0; m_rej <= 0;
        end else begin
            c = m_credit; s = m_sel; v = 0; r = m_refund; rj = 0;
            coin = five_in || ten_in;
            if (m_vend) begin
                c = c - price[m_sel]; s = -1; r = (c > 0); rj = coin;
            end else if (m_refund) begin
                c = c - 1; r = (c > 0); rj = coin;
            end else if (cancel) begin
                s = -1; r = (c > 0); rj = coin;
            end else begin
                if (m_sel >= 0 && m_credit >= price[m_sel]) v = 1;
                else if (item_valid) s = int'(item_sel);
                if (ten_in) begin
                    if (c + 2 <= 20) c = c + 2; else rj = 1;
                    if (five_in) rj = 1;
                end else if (five_in) begin
                    if (c + 1 <= 20) c = c + 1; else rj = 1;
                end
            end
            m_credit <= c; m_sel <= s; m_vend <= v; m_refund <= r; m_rej <= rj;
        end
    end

    // Per-cycle comparison against the model, plus pulse counters.
    always @(negedge clock) begin
        if (!reset) begin
            chk("dispense",      int'(dispense),      int'(m_vend));
            chk("dispense_item", int'(dispense_item), m_vend ? m_sel : 0);
            chk("five_out",      int'(five_out),      int'(m_refund));
            chk("coin_reject",   int'(coin_reject),   int'(m_rej));
            chk("busy",          int'(busy),          int'(m_vend || m_refund));
            chk("credit",        int'(credit),        m_credit);
        end
        if (dispense)   disp_cnt++;
        if (five_out)   five_cnt++;
        if (b_dispense) b_disp_cnt++;
        if (b_five_out) b_five_cnt++;
    end

    task automatic clr();
        item_valid = 0; five_in = 0; ten_in = 0; cancel = 0; item_sel = 0;
    endtask

    task automatic drive(input bit iv, input int is, input bit f, input bit t, input bit c);
        item_valid = iv; item_sel = 2'(is); five_in = f; ten_in = t; cancel = c;
        @(posedge clock); #1;
        clr();
    endtask

    task automatic bdrive(input bit iv, input int is, input bit f, input bit t);
        b_item_valid = iv; b_item_sel = 2'(is); b_five_in = f; b_ten_in = t;
        @(posedge clock); #1;
        b_item_valid = 0; b_five_in = 0; b_ten_in = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        int d0, f0;
        reset = 1; clr();
        b_item_valid = 0; b_item_sel = 0; b_five_in = 0; b_ten_in = 0; b_cancel = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dispense", int'(dispense), 0);
        chk("rst_five_out", int'(five_out), 0);
        reset = 0;
        idle(1);

        // Select item 1 first, then 10,10,5: exact price, no change.
        d0 = disp_cnt; f0 = five_cnt;
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0); chk("t1_cr2", int'(credit), 2);
        drive(0, 0, 0, 1, 0); chk("t1_cr4", int'(credit), 4);
        drive(0, 0, 1, 0, 0); chk("t1_cr5", int'(credit), 5);
        idle(1);
        chk("t1_disp", int'(dispense), 1);
        chk("t1_item", int'(dispense_item), 1);
        idle(3);
        chk("t1_disp_cnt", disp_cnt - d0, 1);
        chk("t1_five_cnt", five_cnt - f0, 0);
        chk("t1_cr_end", int'(credit), 0);
        chk("t1_idle", int'(busy), 0);

        // Coins first, then item 0 (price 3): one change coin.
        d0 = disp_cnt; f0 = five_cnt;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        idle(1);
        chk("t2_disp", int'(dispense), 1);
        chk("t2_item", int'(dispense_item), 0);
        idle(1);
        chk("t2_five", int'(five_out), 1);
        chk("t2_cr1", int'(credit), 1);
        idle(3);
        chk("t2_five_cnt", five_cnt - f0, 1);
        chk("t2_cr_end", int'(credit), 0);

        // Cancel with 5 credit: five refund coins; a ten during refund is refused.
        d0 = disp_cnt; f0 = five_cnt;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        chk("t3_five", int'(five_out), 1);
        drive(0, 0, 0, 1, 0);
        chk("t3_rej", int'(coin_reject), 1);
        chk("t3_cr4", int'(credit), 4);
        idle(8);
        chk("t3_five_cnt", five_cnt - f0, 5);
        chk("t3_disp_cnt", disp_cnt - d0, 0);
        chk("t3_cr_end", int'(credit), 0);

        // Simultaneous coins and the MAX_CREDIT boundary.
        drive(0, 0, 1, 1, 0);
        chk("t4_cr2", int'(credit), 2);
        chk("t4_rej", int'(coin_reject), 1);
        drive(0, 0, 0, 0, 1);
        idle(4);
        repeat (9) drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        chk("t4_cr19", int'(credit), 19);
        drive(0, 0, 0, 1, 0);
        chk("t4_ovf_rej", int'(coin_reject), 1);
        chk("t4_cr19b", int'(credit), 19);
        drive(0, 0, 1, 0, 0);
        chk("t4_cr20", int'(credit), 20);
        chk("t4_no_rej", int'(coin_reject), 0);
        drive(0, 0, 0, 0, 1);
        idle(24);
        chk("t4_cr_end", int'(credit), 0);

        // 3-item instance: index 3 ignored; 2 then 0 vends item 0 at price 3.
        bdrive(1, 3, 0, 0);
        chk("t5_idle", int'(b_busy), 0);
        bdrive(0, 0, 0, 1);
        bdrive(0, 0, 0, 1);
        idle(3);
        chk("t5_cr4", int'(b_credit), 4);
        chk("t5_no_disp", b_disp_cnt, 0);
        bdrive(1, 2, 0, 0);
        idle(2);
        chk("t5_no_disp2", b_disp_cnt, 0);
        bdrive(1, 0, 0, 0);
        idle(1);
        chk("t5_disp", int'(b_dispense), 1);
        chk("t5_item", int'(b_dispense_item), 0);
        idle(4);
        chk("t5_five_cnt", b_five_cnt, 1);
        chk("t5_cr_end", int'(b_credit), 0);

        // Reset during the third refund coin.
        f0 = five_cnt;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        idle(2);
        chk("t6_five3", int'(five_out), 1);
        #2 reset = 1;
        #1;
        chk("t6_rst_five", int'(five_out), 0);
        chk("t6_rst_cr", int'(credit), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_rej", int'(coin_reject), 0);
        @(negedge clock);
        reset = 0;
        @(posedge clock); #1;
        idle(8);
        chk("t6_five_cnt", five_cnt - f0, 2);
        chk("t6_cr_end", int'(credit), 0);

        // Randomized traffic, checked by the per-cycle model comparison.
        repeat (3000) begin
            int r;
            r = int'($urandom_range(0, 99));
            item_valid = ($urandom_range(0, 99) < 15);
            item_sel   = 2'($urandom_range(0, 3));
            five_in    = (r < 20);
            ten_in     = (r >= 12 && r < 35);
            cancel     = ($urandom_range(0, 99) < 3);
            @(posedge clock); #1;
        end
        clr();
        idle(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
